// File: rtl/bist_misr_compactor.sv
// Response-compaction MISR with IDLE/RUN/DONE run control.
// It folds one CUT output beat per accepted cycle and compares the result against a golden signature.
module bist_misr_compactor #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   POLY  = 8'hB8,
    parameter logic [WIDTH-1:0]   SEED  = '0,
    parameter int                 CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_beats,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] resp,
    input  logic             resp_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sig_q, sig_d;
    logic [WIDTH-1:0]   golden_q, golden_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               pass_q, pass_d;
    logic [WIDTH-1:0]   sig_upd;

    // Galois-style shift with tap mask, then fold in the response vector.
    always_comb begin
        sig_upd = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp;
    end

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        golden_d = golden_q;
        rem_d    = rem_q;
        pass_d   = pass_q;
        case (state_q)
            S_RUN: begin
                if (resp_valid) begin
                    sig_d = sig_upd;
                    rem_d = rem_q - 1'b1;
                    // rem is never 0 in RUN, so reaching 1 is the only exit.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        pass_d  = (sig_upd == golden_q);
                    end
                end
            end
            default: begin
                if (start) begin
                    sig_d    = SEED;
                    rem_d    = num_beats;
                    golden_d = golden;
                    pass_d   = 1'b0;
                    if (num_beats != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = (SEED == golden);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sig_q    <= SEED;
            golden_q <= '0;
            rem_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            golden_q <= golden_d;
            rem_q    <= rem_d;
            pass_q   <= pass_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Scoreboard bench for bist_misr_compactor (WIDTH=4, POLY=4'h3, SEED=0).
// Stimulus pushes hand-computed expected outputs; a monitor pops and compares them.
module tb_bist_misr_compactor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_beats = '0;
    logic [WIDTH-1:0] golden = '0;
    logic [WIDTH-1:0] resp = '0;
    logic             resp_valid = 1'b0;
    logic             busy, done, pass;
    logic [WIDTH-1:0] signature;

    bist_misr_compactor #(
        .WIDTH (WIDTH),
        .POLY  (4'h3),
        .SEED  (4'h0),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_beats  (num_beats),
        .golden     (golden),
        .resp       (resp),
        .resp_valid (resp_valid),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sig;
        logic             busy;
        logic             done;
        logic             pass;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    event chk_now;

    // Monitor: one popped expectation per observation point.
    initial begin
        forever begin
            @(posedge clk or chk_now);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                logic ok;
                e  = exp_q.pop_front();
                ok = (signature === e.sig) && (busy === e.busy) && (done === e.done) &&
                     (!e.done || (pass === e.pass));
                n_vec++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL %s: got sig=%h busy=%b done=%b pass=%b, want sig=%h busy=%b done=%b pass=%b",
                             e.name, signature, busy, done, pass, e.sig, e.busy, e.done, e.pass);
                end else begin
                    $display("ok   %s: sig=%h busy=%b done=%b pass=%b", e.name, signature, busy, done, pass);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "timeout");
    end

    function automatic void push(input logic [WIDTH-1:0] s, input logic b, input logic d,
                                 input logic p, input string nm);
        exp_t e;
        e.sig = s; e.busy = b; e.done = d; e.pass = p; e.name = nm;
        exp_q.push_back(e);
    endfunction

    // Drive one cycle's inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic st, input logic [CNT_W-1:0] nb, input logic [WIDTH-1:0] gd,
                       input logic rv, input logic [WIDTH-1:0] rs,
                       input logic [WIDTH-1:0] es, input logic eb, input logic ed,
                       input logic ep, input string nm);
        @(negedge clk);
        start = st; num_beats = nb; golden = gd; resp_valid = rv; resp = rs;
        push(es, eb, ed, ep, nm);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        start = 1'b0; resp_valid = 1'b0;
        rst_n = 1'b0;
        push(4'h0, 1'b0, 1'b0, 1'b0, nm);
        -> chk_now;
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        async_reset("reset_async");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 1, 4'h5, 4'h0, 0, 0, 0, "reset_idle");

        // Basic compaction: 1,2,3 -> 1,0,3, pass.
        cyc(1, 3, 4'h3, 0, 4'h0, 4'h0, 1, 0, 0, "basic_start");
        cyc(0, 0, 0, 1, 4'h1, 4'h1, 1, 0, 0, "basic_b1");
        cyc(0, 0, 0, 1, 4'h2, 4'h0, 1, 0, 0, "basic_b2");
        cyc(0, 0, 0, 1, 4'h3, 4'h3, 0, 1, 1, "basic_b3");
        cyc(0, 0, 0, 1, 4'h5, 4'h3, 0, 1, 1, "done_hold");

        // Feedback: 8,0 -> 8,3, fail; relaunch straight from DONE.
        cyc(1, 2, 4'h5, 0, 4'h0, 4'h0, 1, 0, 0, "fb_restart");
        cyc(0, 0, 0, 1, 4'h8, 4'h8, 1, 0, 0, "fb_b1");
        cyc(0, 0, 0, 1, 4'h0, 4'h3, 0, 1, 0, "fb_b2");

        // Stall with an ignored zero-length start in the middle.
        cyc(1, 3, 4'h3, 0, 4'h0, 4'h0, 1, 0, 0, "stall_start");
        cyc(0, 0, 0, 1, 4'h1, 4'h1, 1, 0, 0, "stall_b1");
        cyc(1, 0, 4'h0, 0, 4'h7, 4'h1, 1, 0, 0, "stall_s1_start");
        cyc(0, 0, 0, 0, 4'h7, 4'h1, 1, 0, 0, "stall_s2");
        cyc(0, 0, 0, 1, 4'h2, 4'h0, 1, 0, 0, "stall_b2");
        cyc(0, 0, 0, 1, 4'h3, 4'h3, 0, 1, 1, "stall_b3_done");

        // Zero-length run, then restart with one beat.
        cyc(1, 0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 1, "zero_start");
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1, "zero_hold");
        cyc(1, 1, 4'hF, 0, 4'h0, 4'h0, 1, 0, 0, "zero_restart");
        cyc(0, 0, 0, 1, 4'hF, 4'hF, 0, 1, 1, "one_beat");

        // Reset mid-run, then a clean rerun of the basic case.
        cyc(1, 3, 4'h3, 0, 4'h0, 4'h0, 1, 0, 0, "abort_start");
        cyc(0, 0, 0, 1, 4'h1, 4'h1, 1, 0, 0, "abort_b1");
        async_reset("abort_reset");
        cyc(0, 0, 0, 1, 4'h2, 4'h0, 0, 0, 0, "abort_idle");
        cyc(1, 3, 4'h3, 0, 4'h0, 4'h0, 1, 0, 0, "rerun_start");
        cyc(0, 0, 0, 1, 4'h1, 4'h1, 1, 0, 0, "rerun_b1");
        cyc(0, 0, 0, 1, 4'h2, 4'h0, 1, 0, 0, "rerun_b2");
        cyc(0, 0, 0, 1, 4'h3, 4'h3, 0, 1, 1, "rerun_b3");

        @(negedge clk);
        resp_valid = 1'b0;
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
